seq_cas_divider: RTL and testbench

- Parametrised, sequential successor to the fixed 7-bit controlled add/subtract (CAS) row.
- Performs unsigned non-restoring division of two WIDTH-bit operands.
- Reuses a single WIDTH+2-bit controlled add/subtract row once per clock instead of instantiating a full CAS array.
- Adds a start/busy/done handshake, divide-by-zero detection and a final remainder-correction cycle, none of which the combinational row has.

---
 rtl/seq_cas_divider_if.sv | 35 +++
 rtl/seq_cas_divider.sv | 132 +++++++++++++
 tb/tb_seq_cas_divider.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_cas_divider_if.sv
// rtl/seq_cas_divider_if.sv - request/result bundle for the sequential CAS divider
//
// Signals:
//   start        request, driven by the master, sampled by the divider only when idle
//   dividend     WIDTH-bit unsigned dividend, captured with an accepted start
//   divisor      WIDTH-bit unsigned divisor, captured with an accepted start
//   busy         divider is iterating or correcting
//   done         one-cycle pulse when quotient/remainder/div_by_zero become valid
//   quotient     WIDTH-bit unsigned quotient
//   remainder    WIDTH-bit unsigned remainder
//   div_by_zero  captured divisor was zero
// Modports: master drives the request side, slave (the divider) drives results.

interface seq_cas_divider_if #(
  parameter int WIDTH = 7
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_cas_divider.sv
// rtl/seq_cas_divider.sv - sequential unsigned non-restoring divider built on one CAS row
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; abandons any division in flight
//   bus   seq_cas_divider_if.slave:
//           start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out
//
// One WIDTH+2-bit controlled add/subtract row is evaluated per ITER cycle,
// followed by a single FIX cycle that restores a negative partial remainder.
// A zero divisor bypasses the iterations and reports all-ones quotient with
// the dividend as remainder.

module seq_cas_divider #(
  parameter int WIDTH = 7
) (
  input  logic              clk,
  input  logic              rst,
  seq_cas_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH+1:0] p;        // signed partial remainder
  logic [WIDTH-1:0] q;        // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] d;        // captured divisor
  logic [CW-1:0]    cnt;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;

  logic [WIDTH+1:0] s;        // {P,Q} shifted left by one, upper part
  logic [WIDTH+1:0] dx;       // zero-extended divisor
  logic [WIDTH+1:0] p_iter;   // CAS row result
  logic [WIDTH+1:0] p_fix;    // remainder after final correction

  // The CAS row: a non-negative partial remainder subtracts the divisor,
  // a negative one adds it back. |S| < 2*D keeps the result inside WIDTH+2 bits.
  always_comb begin
    s      = {p[WIDTH:0], q[WIDTH-1]};
    dx     = {2'b00, d};
    p_iter = p[WIDTH+1] ? (s + dx) : (s - dx);
    p_fix  = p[WIDTH+1] ? (p + dx) : p;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              p      <= '0;
              q      <= bus.dividend;
              d      <= bus.divisor;
              cnt    <= '0;
              dbz_r  <= 1'b0;
              busy_r <= 1'b1;
              state  <= ITER;
            end else begin
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
              done_r      <= 1'b1;
              state       <= DONE;
            end
          end
        end

        ITER: begin
          p   <= p_iter;
          // The new quotient bit is 1 exactly when the new remainder is non-negative.
          q   <= {q[WIDTH-2:0], ~p_iter[WIDTH+1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= FIX;
          end
        end

        FIX: begin
          p           <= p_fix;
          quotient_r  <= q;
          remainder_r <= p_fix[WIDTH-1:0];
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          state       <= DONE;
        end

        DONE: begin
          // start is deliberately not looked at here; the next request is
          // taken in the IDLE cycle that follows.
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_cas_divider.sv
// tb/tb_seq_cas_divider.sv - directed and random scoreboard bench for seq_cas_divider

module tb_seq_cas_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_cas_divider_if #(.WIDTH(7))  if7 ();
  seq_cas_divider_if #(.WIDTH(16)) if16 ();

  seq_cas_divider #(.WIDTH(7))  dut7  (.clk(clk), .rst(rst), .bus(if7.slave));
  seq_cas_divider #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb7[$];
  exp_t sb16[$];

  int n_cmp = 0;
  int n_err = 0;
  int acc7  = 0;
  int acc16 = 0;
  int dn7   = 0;
  int dn16  = 0;

  always @(negedge clk) begin
    if (if7.done === 1'b1)  dn7++;
    if (if16.done === 1'b1) dn16++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Latency is counted in edges from the edge after which start was driven.
  task automatic wait7(input string tag, input int exp_lat, input int exp_busy, input bit rel);
    int n = 0;
    int nb = 0;
    bit seen = 0;
    exp_t e;
    while (!seen && n < 60) begin
      tick();
      n++;
      if (rel && n == 1) if7.start = 1'b0;
      if (if7.busy === 1'b1) nb++;
      if (if7.done === 1'b1) seen = 1;
    end
    chk({tag, "_lat"}, seen ? 64'(n) : '1, 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    if (seen) begin
      chk({tag, "_sb_size"}, 64'(sb7.size() > 0), 64'(1));
      if (sb7.size() > 0) begin
        e = sb7.pop_front();
        chk({tag, "_q"},   64'(if7.quotient),    64'(e.q));
        chk({tag, "_r"},   64'(if7.remainder),   64'(e.r));
        chk({tag, "_dbz"}, 64'(if7.div_by_zero), 64'(e.dbz));
      end
      tick();
      chk({tag, "_done_pulse"}, 64'(if7.done), 64'(0));
    end
  endtask

  task automatic op7(input string tag, input int a, input int b);
    exp_t e;
    if7.dividend = 7'(a);
    if7.divisor  = 7'(b);
    if7.start    = 1'b1;
    e.q   = (b == 0) ? 32'd127 : 32'(a / b);
    e.r   = (b == 0) ? 32'(a) : 32'(a % b);
    e.dbz = (b == 0);
    sb7.push_back(e);
    acc7++;
    wait7(tag, (b == 0) ? 1 : 9, (b == 0) ? 0 : 8, 1'b1);
  endtask

  task automatic op16(input string tag, input int a, input int b);
    exp_t e;
    int n = 0;
    int nb = 0;
    bit seen = 0;
    if16.dividend = 16'(a);
    if16.divisor  = 16'(b);
    if16.start    = 1'b1;
    e.q   = (b == 0) ? 32'd65535 : 32'(a / b);
    e.r   = (b == 0) ? 32'(a) : 32'(a % b);
    e.dbz = (b == 0);
    sb16.push_back(e);
    acc16++;
    while (!seen && n < 80) begin
      tick();
      n++;
      if (n == 1) if16.start = 1'b0;
      if (if16.busy === 1'b1) nb++;
      if (if16.done === 1'b1) seen = 1;
    end
    chk({tag, "_lat"}, seen ? 64'(n) : '1, (b == 0) ? 64'(1) : 64'(18));
    chk({tag, "_busy_cycles"}, 64'(nb), (b == 0) ? 64'(0) : 64'(17));
    if (seen) begin
      chk({tag, "_sb_size"}, 64'(sb16.size() > 0), 64'(1));
      if (sb16.size() > 0) begin
        e = sb16.pop_front();
        chk({tag, "_q"},   64'(if16.quotient),    64'(e.q));
        chk({tag, "_r"},   64'(if16.remainder),   64'(e.r));
        chk({tag, "_dbz"}, 64'(if16.div_by_zero), 64'(e.dbz));
        if (b != 0) begin
          chk({tag, "_inv"}, 64'(if16.quotient) * 64'(b) + 64'(if16.remainder), 64'(a));
        end
      end
      tick();
      chk({tag, "_done_pulse"}, 64'(if16.done), 64'(0));
    end
  endtask

  initial begin
    exp_t e;
    int nd;
    if7.start = 1'b0;  if7.dividend = '0;  if7.divisor = '0;
    if16.start = 1'b0; if16.dividend = '0; if16.divisor = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", 64'(if7.busy), 64'(0));
    chk("rst_done", 64'(if7.done), 64'(0));
    chk("rst_q",    64'(if7.quotient), 64'(0));
    chk("rst_r",    64'(if7.remainder), 64'(0));
    chk("rst_dbz",  64'(if7.div_by_zero), 64'(0));
    chk("rst16_q",  64'(if16.quotient), 64'(0));
    chk("rst16_busy", 64'(if16.busy), 64'(0));
    rst = 1'b0;
    tick();

    // Directed operands
    op7("d100_7", 100, 7);
    op7("d127_1", 127, 1);
    op7("d127_127", 127, 127);
    op7("d5_9", 5, 9);
    op7("d0_3", 0, 3);
    op7("d50_0", 50, 0);
    op7("d9_3", 9, 3);

    // start held high; new operands presented while busy must not disturb 100/7
    if7.dividend = 7'd100;
    if7.divisor  = 7'd7;
    if7.start    = 1'b1;
    e.q = 32'd14; e.r = 32'd2; e.dbz = 1'b0;
    sb7.push_back(e);
    acc7++;
    tick();
    chk("hold_accept_busy", 64'(if7.busy), 64'(1));
    if7.dividend = 7'd60;
    if7.divisor  = 7'd5;
    // Already one edge past the drive edge, so the remaining latency is 8.
    wait7("hold_first", 8, 7, 1'b0);
    chk("hold_idle_busy", 64'(if7.busy), 64'(0));
    e.q = 32'd12; e.r = 32'd0; e.dbz = 1'b0;
    sb7.push_back(e);
    acc7++;
    wait7("hold_second", 9, 8, 1'b1);

    // Reset during the 4th ITER cycle
    if7.dividend = 7'd100;
    if7.divisor  = 7'd7;
    if7.start    = 1'b1;
    tick();
    if7.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy_before", 64'(if7.busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(if7.busy), 64'(0));
    chk("abort_done", 64'(if7.done), 64'(0));
    chk("abort_q",    64'(if7.quotient), 64'(0));
    chk("abort_r",    64'(if7.remainder), 64'(0));
    chk("abort_dbz",  64'(if7.div_by_zero), 64'(0));
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if7.done === 1'b1) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'(0));
    op7("after_abort_100_7", 100, 7);

    // WIDTH=16 directed
    op16("w16_65535_1", 65535, 1);
    op16("w16_1000_0", 1000, 0);
    op16("w16_3_65535", 3, 65535);

    // Random vectors
    for (int i = 0; i < 1000; i++) begin
      op7("rnd7", int'($urandom_range(0, 127)), int'($urandom_range(1, 127)));
    end
    for (int i = 0; i < 1000; i++) begin
      op16("rnd16", int'($urandom_range(0, 65535)), int'($urandom_range(1, 65535)));
    end

    tick();
    chk("done_count7",  64'(dn7),  64'(acc7));
    chk("done_count16", 64'(dn16), 64'(acc16));
    chk("sb7_empty",  64'(sb7.size()),  64'(0));
    chk("sb16_empty", 64'(sb16.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
